// File: rtl/codec_sample_frontend.sv
// Codec capture front end: pops stereo samples, combines channels per mode,
// averages DECIM captures, saturates to N bits and buffers results in a FIFO.
module codec_sample_frontend #(
  parameter int IN_W  = 24,
  parameter int N     = 16,
  parameter int DECIM = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   read_ready,
  output logic                   read,
  input  logic [IN_W-1:0]        readdata_left,
  input  logic [IN_W-1:0]        readdata_right,
  output logic [N-1:0]           sample_out,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int CW    = (LOG2D > 0) ? LOG2D : 1;
  localparam int ACC_W = IN_W + 1 + LOG2D;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_WAIT} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]              mode_q, mode_d;
  logic                    push_q, push_d;
  logic [N-1:0]            pdata_q, pdata_d;

  logic [N-1:0]            mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    ovf_q, ovf_d;

  logic                    capture;
  logic                    first;
  logic                    last;
  logic [1:0]              mode_eff;
  logic signed [IN_W:0]    left_x, right_x, comb;
  logic signed [ACC_W-1:0] comb_x, acc_sum;
  logic [N-1:0]            out_smp;

  logic                    empty, full, pop, wr_en, drop;

  // ---------------- capture FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    read    = 1'b0;
    case (state_q)
      S_IDLE: if (read_ready) state_d = S_POP;
      S_POP: begin
        read    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- channel combine and decimation ----------------
  assign capture  = (state_q == S_POP);
  assign first    = (cnt_q == '0);
  assign last     = (cnt_q == CW'(DECIM - 1));
  assign mode_eff = first ? mode : mode_q;

  always_comb begin
    left_x  = $signed({readdata_left[IN_W-1], readdata_left});
    right_x = $signed({readdata_right[IN_W-1], readdata_right});
    comb    = left_x;
    case (mode_eff)
      2'd0: comb = left_x;
      2'd1: comb = right_x;
      2'd2: comb = left_x + right_x;
      2'd3: comb = left_x - right_x;
    endcase
    comb_x  = ACC_W'(comb);
    acc_sum = first ? comb_x : (acc_q + comb_x);
  end

  // Shifting right by LOG2D leaves a mean that needs at most IN_W+1 bits, so
  // the in-range test reduces to the two top accumulator bits agreeing, and
  // the output slice is taken straight from the unshifted sum.
  always_comb begin
    if (acc_sum[ACC_W-1] == acc_sum[ACC_W-2])
      out_smp = acc_sum[ACC_W-2 -: N];
    else if (acc_sum[ACC_W-1])
      out_smp = {1'b1, {(N-1){1'b0}}};
    else
      out_smp = {1'b0, {(N-1){1'b1}}};
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    push_d  = 1'b0;
    pdata_d = pdata_q;
    if (capture) begin
      mode_d = mode_eff;
      if (last) begin
        cnt_d   = '0;
        acc_d   = '0;
        push_d  = 1'b1;
        pdata_d = out_smp;
      end else begin
        cnt_d = cnt_q + CW'(1);
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mode_q  <= '0;
      push_q  <= 1'b0;
      pdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      push_q  <= push_d;
      pdata_q <= pdata_d;
    end
  end

  // ---------------- output FIFO ----------------
  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign pop   = !empty && sample_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr_en = push_q && (!full || pop);
  assign drop  = push_q && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop)              ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pdata_q;
  end

  assign sample_out   = empty ? '0 : mem_q[rd_ptr_q];
  assign sample_valid = !empty;
  assign fifo_level   = level_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_codec_sample_frontend.sv
// Scoreboard bench: unit 0 runs DECIM=1, unit 1 runs DECIM=4, both DEPTH=4.
module tb_codec_sample_frontend;

  logic        clk;
  logic        rst_n [2];
  logic [1:0]  md    [2];
  logic        rr    [2];
  logic        rd    [2];
  logic [23:0] dl    [2];
  logic [23:0] dr    [2];
  logic [15:0] so    [2];
  logic        sv    [2];
  logic        srdy  [2];
  logic [2:0]  lvl   [2];
  logic        ovf   [2];
  logic        clr   [2];

  int n_checks = 0;
  int n_pass   = 0;
  int rd_cnt [2] = '{0, 0};
  int r0;
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] e0, e1;

  codec_sample_frontend #(.IN_W(24), .N(16), .DECIM(1), .DEPTH(4)) u_d1 (
    .clk(clk), .rst(rst_n[0]), .mode(md[0]), .read_ready(rr[0]), .read(rd[0]),
    .readdata_left(dl[0]), .readdata_right(dr[0]), .sample_out(so[0]),
    .sample_valid(sv[0]), .sample_ready(srdy[0]), .fifo_level(lvl[0]),
    .overflow(ovf[0]), .clr_overflow(clr[0])
  );

  codec_sample_frontend #(.IN_W(24), .N(16), .DECIM(4), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst_n[1]), .mode(md[1]), .read_ready(rr[1]), .read(rd[1]),
    .readdata_left(dl[1]), .readdata_right(dr[1]), .sample_out(so[1]),
    .sample_valid(sv[1]), .sample_ready(srdy[1]), .fifo_level(lvl[1]),
    .overflow(ovf[1]), .clr_overflow(clr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void expect_s(input int k, input logic [15:0] v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endfunction

  // One codec transfer: raise read_ready, wait for the read strobe, drop it.
  task automatic capture(input int k, input logic [23:0] l, input logic [23:0] r);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    dl[k] = l; dr[k] = r; rr[k] = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rd[k]) begin got = 1'b1; break; end
    end
    check("read_strobe_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    rr[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rd[0]) rd_cnt[0]++;
    if (rd[1]) rd_cnt[1]++;
  end

  always @(negedge clk) begin
    if (sv[0] && srdy[0]) begin
      if (q0.size() == 0) check("unexpected_out0", 32'(so[0]), 32'hDEAD_0000);
      else begin e0 = q0.pop_front(); check("out0", 32'(so[0]), 32'(e0)); end
    end
  end

  always @(negedge clk) begin
    if (sv[1] && srdy[1]) begin
      if (q1.size() == 0) check("unexpected_out1", 32'(so[1]), 32'hDEAD_0000);
      else begin e1 = q1.pop_front(); check("out1", 32'(so[1]), 32'(e1)); end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; md[k] = 2'd0; rr[k] = 1'b0; dl[k] = '0; dr[k] = '0;
      srdy[k] = 1'b0; clr[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_read", 32'(rd[k]), 0);
      check("rst_valid", 32'(sv[k]), 0);
      check("rst_level", 32'(lvl[k]), 0);
      check("rst_ovf", 32'(ovf[k]), 0);
      check("rst_sample", 32'(so[k]), 0);
    end
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Single capture, DECIM=1: latency and single read pulse
    r0 = rd_cnt[0];
    expect_s(0, 16'h1234);
    capture(0, 24'h123456, 24'h000000);
    @(negedge clk); check("A_valid_edge1", 32'(sv[0]), 0);
    @(negedge clk); check("A_valid_edge2", 32'(sv[0]), 1);
    check("A_head", 32'(so[0]), 32'h1234);
    check("A_one_read", 32'(rd_cnt[0] - r0), 1);
    @(posedge clk); #1; srdy[0] = 1'b1;
    repeat (2) @(negedge clk);

    // Mode combinations and saturation
    md[0] = 2'd2; expect_s(0, 16'h7FFF); capture(0, 24'h400000, 24'h400000);
    md[0] = 2'd3; expect_s(0, 16'hFFFE); capture(0, 24'h000100, 24'h000300);
    md[0] = 2'd2; expect_s(0, 16'h8000); capture(0, 24'h800000, 24'h800000);
    md[0] = 2'd1; expect_s(0, 16'hABCD); capture(0, 24'h000000, 24'hABCDEF);
    md[0] = 2'd0;
    repeat (4) @(negedge clk);

    // DECIM=4 averaging, one output only after the 4th capture
    srdy[1] = 1'b1;
    expect_s(1, 16'h2800);
    capture(1, 24'h100000, 24'h0);
    capture(1, 24'h200000, 24'h0);
    capture(1, 24'h300000, 24'h0);
    repeat (3) @(negedge clk);
    check("C_no_early_output", 32'(sv[1]), 0);
    capture(1, 24'h400000, 24'h0);
    repeat (4) @(negedge clk);

    // Mode latched on the first capture of a window
    expect_s(1, 16'h0400);
    md[1] = 2'd1; capture(1, 24'h7FFFFF, 24'h040000);
    md[1] = 2'd0;
    for (int i = 0; i < 3; i++) capture(1, 24'h7FFFFF, 24'h040000);
    repeat (4) @(negedge clk);

    // FIFO full, drop, push+pop on full, overflow clear semantics
    @(posedge clk); #1; srdy[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_s(0, 16'(i << 8));
      capture(0, 24'(i << 16), 24'h0);
    end
    capture(0, 24'h050000, 24'h0);
    repeat (2) @(negedge clk);
    check("D_level_full", 32'(lvl[0]), 4);
    check("D_ovf_set", 32'(ovf[0]), 1);
    check("D_head_first", 32'(so[0]), 32'h0100);
    expect_s(0, 16'h0600);
    capture(0, 24'h060000, 24'h0);
    srdy[0] = 1'b1;
    @(posedge clk); #1; srdy[0] = 1'b0;
    @(negedge clk);
    check("D_level_pushpop_full", 32'(lvl[0]), 4);
    check("D_head_after_pop", 32'(so[0]), 32'h0200);
    check("D_ovf_sticky", 32'(ovf[0]), 1);
    @(posedge clk); #1; clr[0] = 1'b1;
    @(posedge clk); #1; clr[0] = 1'b0;
    @(negedge clk); check("D_ovf_cleared", 32'(ovf[0]), 0);
    capture(0, 24'h070000, 24'h0);
    clr[0] = 1'b1;
    @(posedge clk); #1; clr[0] = 1'b0;
    @(negedge clk);
    check("D_drop_beats_clear", 32'(ovf[0]), 1);
    check("D_level_after_drop", 32'(lvl[0]), 4);
    @(posedge clk); #1; clr[0] = 1'b1;
    @(posedge clk); #1; clr[0] = 1'b0;
    @(negedge clk); check("D_ovf_cleared2", 32'(ovf[0]), 0);
    @(posedge clk); #1; srdy[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("D_drained", 32'(lvl[0]), 0);

    // read_ready held high: one pop every three cycles
    r0 = rd_cnt[0];
    for (int i = 0; i < 4; i++) expect_s(0, 16'h1111);
    @(posedge clk); #1;
    dl[0] = 24'h111100; dr[0] = 24'h0; rr[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("E_read_pattern", 32'(rd[0]), 32'((i % 3) == 1));
    end
    @(posedge clk); #1; rr[0] = 1'b0;
    @(negedge clk); check("E_last_pulse", 32'(rd[0]), 1);
    repeat (6) @(negedge clk);
    check("E_pulse_count", 32'(rd_cnt[0] - r0), 4);

    // Reset during POP discards the partial window
    @(posedge clk); #1; srdy[1] = 1'b0;
    for (int i = 0; i < 4; i++) capture(1, 24'h080000, 24'h0);
    repeat (2) @(negedge clk);
    check("F_level_before_rst", 32'(lvl[1]), 1);
    check("F_head_before_rst", 32'(so[1]), 32'h0800);
    capture(1, 24'h100000, 24'h0);
    capture(1, 24'h100000, 24'h0);
    @(posedge clk); #1;
    dl[1] = 24'h100000; rr[1] = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        if (rd[1]) begin got = 1'b1; break; end
      end
      check("F_pop_reached", 32'(got), 1);
    end
    rst_n[1] = 1'b0;
    #1;
    check("F_rst_read", 32'(rd[1]), 0);
    check("F_rst_valid", 32'(sv[1]), 0);
    check("F_rst_level", 32'(lvl[1]), 0);
    check("F_rst_ovf", 32'(ovf[1]), 0);
    check("F_rst_sample", 32'(so[1]), 0);
    rr[1] = 1'b0;
    @(negedge clk); rst_n[1] = 1'b1;
    @(posedge clk); #1; srdy[1] = 1'b1;
    expect_s(1, 16'h2000);
    for (int i = 0; i < 3; i++) capture(1, 24'h200000, 24'h0);
    repeat (3) @(negedge clk);
    check("F_no_output_after_3", 32'(sv[1]), 0);
    capture(1, 24'h200000, 24'h0);
    repeat (5) @(negedge clk);

    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
